// File: rtl/zigbee_pkg.sv
// Shared widths and types for the 802.15.4 O-QPSK symbol/word datapath.
package zigbee_pkg;

   localparam int unsigned NIBBLE_W  = 4;
   localparam int unsigned N_NIBBLES = 4;
   localparam int unsigned WORD_W    = NIBBLE_W * N_NIBBLES;
   // The assembly register only ever holds the first N_NIBBLES-1 nibbles.
   localparam int unsigned ASM_W     = WORD_W - NIBBLE_W;

   typedef logic [NIBBLE_W-1:0] nibble_t;
   typedef logic [WORD_W-1:0]   word_t;
   typedef logic [1:0]          nib_cnt_t;
   typedef logic [ASM_W-1:0]    asm_t;

endpackage : zigbee_pkg

// File: rtl/nibble_word_packer.sv
// Packs four received 4-bit symbols (low nibble first) into a 16-bit word.
// Double-buffered: the assembly register and the output register let a new
// word complete in the same cycle the previous one is drained.
module nibble_word_packer
   import zigbee_pkg::*;
(
   input  logic                clk,
   input  logic                resetn,
   input  logic [NIBBLE_W-1:0] inNibble,
   input  logic                inNibbleValid,
   output logic                outNibbleReady,
   input  logic                inFlush,
   output logic [WORD_W-1:0]   outWord,
   output logic                outWordValid,
   input  logic                inWordReady,
   output logic [1:0]          outCount
);

   localparam nib_cnt_t LAST_CNT = nib_cnt_t'(N_NIBBLES - 1);

   nib_cnt_t cnt_q,   cnt_d;
   asm_t     asm_q,   asm_d;
   word_t    word_q,  word_d;
   logic     valid_q, valid_d;

   logic accept;
   logic consume;
   logic load;

   // Only the completing nibble can stall, and only if the output register
   // stays occupied through this edge.
   assign outNibbleReady = !((cnt_q == LAST_CNT) && valid_q && !inWordReady);

   assign accept  = inNibbleValid && outNibbleReady;
   assign consume = valid_q && inWordReady;
   assign load    = accept && !inFlush && (cnt_q == LAST_CNT);

   // Next-state for nibble counter, assembly register and output register.
   always_comb begin
      cnt_d   = cnt_q;
      asm_d   = asm_q;
      word_d  = word_q;
      valid_d = valid_q;

      if (inFlush) begin
         cnt_d = '0;
         asm_d = '0;
      end else if (accept) begin
         if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
            asm_d = '0;
         end else begin
            cnt_d = nib_cnt_t'(cnt_q + nib_cnt_t'(1));
            for (int k = 0; k < int'(N_NIBBLES) - 1; k++) begin
               if (cnt_q == nib_cnt_t'(k)) begin
                  asm_d[k*NIBBLE_W +: NIBBLE_W] = inNibble;
               end
            end
         end
      end

      // Load wins over consume so a drain-and-refill keeps valid high.
      if (load) begin
         word_d  = {inNibble, asm_q};
         valid_d = 1'b1;
      end else if (consume) begin
         valid_d = 1'b0;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q   <= '0;
         asm_q   <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
         word_q  <= word_d;
         valid_q <= valid_d;
      end
   end

   assign outWord      = word_q;
   assign outWordValid = valid_q;
   assign outCount     = cnt_q;

endmodule : nibble_word_packer

// File: tb/tb_nibble_word_packer.sv
// Scoreboard bench for nibble_word_packer: directed nibble streams push the
// hand-computed words they should produce; a monitor pops on each consume.
module tb_nibble_word_packer;

   logic        clk;
   logic        resetn;
   logic [3:0]  inNibble;
   logic        inNibbleValid;
   logic        outNibbleReady;
   logic        inFlush;
   logic [15:0] outWord;
   logic        outWordValid;
   logic        inWordReady;
   logic [1:0]  outCount;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [15:0] exp_q[$];
   int          cons_cyc_q[$];

   logic        hold_pend = 1'b0;
   logic [15:0] hold_word = '0;

   nibble_word_packer dut (
      .clk            (clk),
      .resetn         (resetn),
      .inNibble       (inNibble),
      .inNibbleValid  (inNibbleValid),
      .outNibbleReady (outNibbleReady),
      .inFlush        (inFlush),
      .outWord        (outWord),
      .outWordValid   (outWordValid),
      .inWordReady    (inWordReady),
      .outCount       (outCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: compares each word at the cycle it is consumed, and checks
   // that a stalled word does not change.
   always @(negedge clk) begin
      if (resetn && outWordValid) begin
         if (hold_pend) check("stall_stable", 32'(outWord), 32'(hold_word));
         if (inWordReady) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", 32'(outWord), 32'hFFFF_FFFF);
            end else begin
               check("word", 32'(outWord), 32'(exp_q.pop_front()));
            end
            cons_cyc_q.push_back(cyc);
            hold_pend = 1'b0;
         end else begin
            hold_pend = 1'b1;
            hold_word = outWord;
         end
      end else begin
         hold_pend = 1'b0;
      end
   end

   // Present one nibble until accepted (bounded), return at posedge+1.
   task automatic send(input logic [3:0] n, input logic flush);
      bit ok = 1'b0;
      inNibble      = n;
      inNibbleValid = 1'b1;
      inFlush       = flush;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (outNibbleReady) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("accept_timeout", 32'(0), 32'(1));
      @(posedge clk);
      #1;
      inNibbleValid = 1'b0;
      inFlush       = 1'b0;
   endtask

   task automatic idle(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c1, c2;
      resetn        = 1'b0;
      inNibble      = '0;
      inNibbleValid = 1'b0;
      inFlush       = 1'b0;
      inWordReady   = 1'b1;
      #23 resetn = 1'b1;
      idle(1);

      // Reset values
      check("rst_valid", 32'(outWordValid), 32'(0));
      check("rst_word",  32'(outWord),      32'(0));
      check("rst_count", 32'(outCount),     32'(0));
      check("rst_ready", 32'(outNibbleReady), 32'(1));

      // Basic pack 1,2,3,4 -> 4321, count 1,2,3,0, one-cycle latency
      exp_q.push_back(16'h4321);
      send(4'h1, 1'b0); check("cnt_1", 32'(outCount), 32'(1));
      send(4'h2, 1'b0); check("cnt_2", 32'(outCount), 32'(2));
      send(4'h3, 1'b0); check("cnt_3", 32'(outCount), 32'(3));
      check("valid_before", 32'(outWordValid), 32'(0));
      send(4'h4, 1'b0); check("cnt_0", 32'(outCount), 32'(0));
      check("valid_latency", 32'(outWordValid), 32'(1));
      check("word_latency",  32'(outWord), 32'(16'h4321));
      idle(1);
      check("valid_pulse_end", 32'(outWordValid), 32'(0));

      // Back-to-back 1..8, words exactly 4 cycles apart
      cons_cyc_q.delete();
      exp_q.push_back(16'h4321);
      exp_q.push_back(16'h8765);
      for (int i = 1; i <= 8; i++) begin
         check("b2b_ready", 32'(outNibbleReady), 32'(1));
         send(4'(i), 1'b0);
      end
      idle(2);
      check("b2b_words", 32'(cons_cyc_q.size()), 32'(2));
      if (cons_cyc_q.size() == 2) begin
         c1 = cons_cyc_q.pop_front();
         c2 = cons_cyc_q.pop_front();
         check("b2b_gap", 32'(c2 - c1), 32'(4));
      end

      // Stall: DCBA held, completing nibble 4 blocked, then drain+load
      inWordReady = 1'b0;
      exp_q.push_back(16'hDCBA);
      exp_q.push_back(16'h4321);
      send(4'hA, 1'b0); send(4'hB, 1'b0); send(4'hC, 1'b0); send(4'hD, 1'b0);
      send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0);
      check("stall_cnt", 32'(outCount), 32'(3));
      inNibble      = 4'h4;
      inNibbleValid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_ready", 32'(outNibbleReady), 32'(0));
         check("stall_word",  32'(outWord), 32'(16'hDCBA));
      end
      @(posedge clk); #1;
      inWordReady = 1'b1;
      @(negedge clk);
      check("drain_ready", 32'(outNibbleReady), 32'(1));
      @(posedge clk); #1;
      inNibbleValid = 1'b0;
      check("reload_valid", 32'(outWordValid), 32'(1));
      check("reload_word",  32'(outWord), 32'(16'h4321));
      check("reload_cnt",   32'(outCount), 32'(0));
      idle(2);

      // Flush discards 5,6 and the simultaneous 7
      exp_q.push_back(16'h4321);
      send(4'h5, 1'b0); send(4'h6, 1'b0);
      send(4'h7, 1'b1);
      check("flush_cnt", 32'(outCount), 32'(0));
      send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b0);
      idle(2);

      // Asynchronous reset mid-word
      send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0);
      #3 resetn = 1'b0;
      #1;
      check("arst_count", 32'(outCount), 32'(0));
      check("arst_valid", 32'(outWordValid), 32'(0));
      check("arst_word",  32'(outWord), 32'(0));
      check("arst_ready", 32'(outNibbleReady), 32'(1));
      #10 resetn = 1'b1;
      @(posedge clk); #1;
      exp_q.push_back(16'hCBA9);
      send(4'h9, 1'b0); send(4'hA, 1'b0); send(4'hB, 1'b0); send(4'hC, 1'b0);
      idle(2);

      // Flush with a pending word only clears the count
      inWordReady = 1'b0;
      exp_q.push_back(16'h4321);
      send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b0);
      send(4'h5, 1'b0);
      check("pend_cnt", 32'(outCount), 32'(1));
      inFlush = 1'b1;
      @(posedge clk); #1;
      inFlush = 1'b0;
      check("pflush_cnt",   32'(outCount), 32'(0));
      check("pflush_valid", 32'(outWordValid), 32'(1));
      check("pflush_word",  32'(outWord), 32'(16'h4321));
      idle(1);
      inWordReady = 1'b1;
      idle(3);
      check("pflush_drained", 32'(outWordValid), 32'(0));

      check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_nibble_word_packer
